// File: rtl/sq_diff_iter.sv
// ============================================================================
// Module      : sq_diff_iter
// Description : Iterative approximate squared-difference unit. Computes
//               |a-b|^2 by shift-add, one multiplier bit per cycle, with the
//               low TRUNC partial-product columns forced to zero.
//               Optional error monitor: SQ_DIFF_ERR_MON_EN
//                 defined   -> exact shadow accumulator, err/err_max live
//                 undefined -> err/err_max tied to zero
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sq_diff_iter #(
    parameter int W     = 6,
    parameter int TRUNC = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*W-1:0]   result,
    output logic [2*W-1:0]   err,
    output logic [2*W-1:0]   err_max
);

    localparam int OW = 2 * W;
    localparam int CW = (W > 1) ? $clog2(W) : 1;

    localparam logic [OW-1:0] c_ONE  = OW'(1);
    // Keeps columns [OW-1:TRUNC] of each partial product, clears the rest
    localparam logic [OW-1:0] c_MASK = ~((c_ONE << TRUNC) - c_ONE);
    localparam logic [CW-1:0] c_LAST = CW'(W - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;

    logic [W-1:0]    r_d;
    logic [CW-1:0]   r_cnt;
    logic [OW-1:0]   r_acc;
    logic [OW-1:0]   r_result;

    logic            w_accept;
    logic            w_last;
    logic [W-1:0]    w_diff;
    logic [OW-1:0]   w_shift;
    logic [OW-1:0]   w_term;
    logic [OW-1:0]   w_acc_nxt;

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign result    = r_result;

    assign w_accept  = in_valid & in_ready;
    assign w_last    = (r_state == S_CALC) && (r_cnt == c_LAST);
    // Magnitude only; squaring makes the sign irrelevant
    assign w_diff    = (a >= b) ? (a - b) : (b - a);
    assign w_shift   = {{W{1'b0}}, r_d} << r_cnt;
    assign w_term    = r_d[r_cnt] ? (w_shift & c_MASK) : '0;
    assign w_acc_nxt = r_acc + w_term;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state: capture, fixed W-cycle iteration, hold until consumed
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept)  w_state_nxt = S_CALC;
            S_CALC:  if (w_last)    w_state_nxt = S_DONE;
            S_DONE:  if (out_ready) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Operand capture, shift-add iteration and result latch
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_d      <= '0;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_result <= '0;
        end else begin
            if (w_accept) begin
                r_d   <= w_diff;
                r_cnt <= '0;
                r_acc <= '0;
            end else if (r_state == S_CALC) begin
                r_acc <= w_acc_nxt;
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_last) begin
                r_result <= w_acc_nxt;
            end
        end
    end

`ifdef SQ_DIFF_ERR_MON_EN
    logic [OW-1:0] r_acc_ex;
    logic [OW-1:0] r_err;
    logic [OW-1:0] r_err_max;
    logic [OW-1:0] w_term_ex;
    logic [OW-1:0] w_acc_ex_nxt;
    logic [OW-1:0] w_err_nxt;

    assign w_term_ex    = r_d[r_cnt] ? w_shift : '0;
    assign w_acc_ex_nxt = r_acc_ex + w_term_ex;
    // Masking only removes bits, so exact >= approximate and this never wraps
    assign w_err_nxt    = w_acc_ex_nxt - w_acc_nxt;
    assign err          = r_err;
    assign err_max      = r_err_max;

    // Exact shadow accumulator and error tracking, committed with the result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc_ex  <= '0;
            r_err     <= '0;
            r_err_max <= '0;
        end else begin
            if (w_accept) begin
                r_acc_ex <= '0;
            end else if (r_state == S_CALC) begin
                r_acc_ex <= w_acc_ex_nxt;
            end
            if (w_last) begin
                r_err <= w_err_nxt;
                if (w_err_nxt > r_err_max) begin
                    r_err_max <= w_err_nxt;
                end
            end
        end
    end
`else
    assign err     = '0;
    assign err_max = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_sq_diff_iter.sv
// ============================================================================
// Module      : tb_sq_diff_iter
// Description : Self-checking bench for sq_diff_iter. Three instances with
//               TRUNC = 0, 3, 6 share one stimulus stream and are compared
//               against an arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sq_diff_iter;

    localparam int W  = 6;
    localparam int OW = 2 * W;
    localparam int NG = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic [W-1:0]  a = '0;
    logic [W-1:0]  b = '0;

    logic          in_ready  [NG];
    logic          out_valid [NG];
    logic [OW-1:0] result    [NG];
    logic [OW-1:0] err       [NG];
    logic [OW-1:0] err_max   [NG];

    int n_checks = 0;
    int n_errors = 0;
    int exp_max [NG];

    for (genvar g = 0; g < NG; g++) begin : g_dut
        sq_diff_iter #(
            .W     (W),
            .TRUNC (3 * g)
        ) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (in_valid),
            .in_ready  (in_ready[g]),
            .a         (a),
            .b         (b),
            .out_valid (out_valid[g]),
            .out_ready (out_ready),
            .result    (result[g]),
            .err       (err[g]),
            .err_max   (err_max[g])
        );
    end

    always #5 clk = ~clk;

    // Single comparison point: counts and reports mismatches
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: square of d with every bit of weight below 2^trunc dropped
    // from each partial product d*2^i (for each set bit i of d)
    function automatic int model_sq(input int d, input int trunc);
        int s;
        int pp;
        s = 0;
        for (int i = 0; i < W; i++) begin
            if (((d >> i) & 1) == 1) begin
                pp = d * (2 ** i);
                s  = s + (pp - (pp % (2 ** trunc)));
            end
        end
        return s;
    endfunction

    task automatic run_op(input int av, input int bv, input int hold);
        int d;
        int exact;
        int approx;
        int e;
        int lat;
        logic [OW-1:0] held [NG];
        @(negedge clk);
        for (int g = 0; g < NG; g++) check("idle_in_ready", in_ready[g], 1);
        a = W'(av); b = W'(bv); in_valid = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        a = W'($urandom); b = W'($urandom);
        d = (av > bv) ? av - bv : bv - av;
        exact = d * d;
        lat = 1;
        while (out_valid[0] !== 1'b1 && lat < 40) begin
            check("busy_in_ready", in_ready[0], 0);
            @(negedge clk);
            lat++;
        end
        check("latency", lat, W + 1);
        if (out_valid[0] !== 1'b1) return;
        for (int g = 0; g < NG; g++) begin
            approx = model_sq(d, 3 * g);
            check("out_valid", out_valid[g], 1);
            check("result", result[g], approx);
            check("result_le_exact", (32'(result[g]) <= exact), 1);
`ifdef SQ_DIFF_ERR_MON_EN
            e = exact - approx;
            if (e > exp_max[g]) exp_max[g] = e;
`else
            e = 0;
`endif
            check("err", err[g], e);
            check("err_max", err_max[g], exp_max[g]);
            held[g] = result[g];
        end
        // Backpressure: stray in_valid pulses must be ignored while DONE
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            a = W'($urandom); b = W'($urandom);
            @(negedge clk);
            check("hold_valid", out_valid[0], 1);
            check("hold_result", result[0], held[0]);
            check("hold_in_ready", in_ready[0], 0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("drop_valid", out_valid[0], 0);
        check("back_idle", in_ready[0], 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int g = 0; g < NG; g++) exp_max[g] = 0;
        @(negedge clk);
        @(negedge clk);
        for (int g = 0; g < NG; g++) begin
            check("rst_in_ready", in_ready[g], 1);
            check("rst_out_valid", out_valid[g], 0);
            check("rst_result", result[g], 0);
            check("rst_err", err[g], 0);
            check("rst_err_max", err_max[g], 0);
        end
        rst_n = 1'b1;

        run_op(45, 3, 0);
        run_op(3, 45, 5);
        run_op(0, 63, 1);
        run_op(37, 37, 0);
        run_op(63, 0, 2);

        // Reset in the middle of CALC
        @(negedge clk);
        a = 6'd45; b = 6'd3; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        for (int g = 0; g < NG; g++) begin
            check("midrst_out_valid", out_valid[g], 0);
            check("midrst_in_ready", in_ready[g], 1);
            check("midrst_result", result[g], 0);
            check("midrst_err_max", err_max[g], 0);
            exp_max[g] = 0;
        end
        @(negedge clk);
        rst_n = 1'b1;
        run_op(45, 3, 0);

        for (int n = 0; n < 1500; n++) begin
            run_op(int'($urandom_range(0, 63)), int'($urandom_range(0, 63)),
                   int'($urandom_range(0, 2)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
